// File: rtl/eth_rx_pkg.sv
// Shared receive-path definitions: framer FSM encoding, GMII delimiter bytes, output beat layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package eth_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DROP     = 2'd3
    } rx_state_t;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    // One registered output beat; len and bad only mean something alongside eof.
    typedef struct packed {
        logic        vld;
        logic [7:0]  dat;
        logic        sof;
        logic        eof;
        logic        bad;
        logic [10:0] len;
    } rx_beat_t;

endpackage

// File: rtl/sat_cnt16.sv
// 16-bit event counter that sticks at 0xFFFF instead of wrapping.
// Latency: count reflects an increment request one cycle later.
// Backpressure: none; requests at saturation are ignored.
module sat_cnt16 (
    input  logic        gmii_clk,
    input  logic        rst,
    input  logic        inc,
    output logic [15:0] cnt
);

    always_ff @(posedge gmii_clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != 16'hFFFF)) begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD, delimits frames, flags runt/oversize/abort, counts events.
// Latency: 2 cycles from gmii_din to rx_data; eof lands one cycle after gmii_den falls.
// Backpressure: none; GMII cannot stall, so the consumer must take every rx_vld beat.
module gmii_rx_framer
    import eth_rx_pkg::*;
#(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        gmii_clk,
    input  logic        rst,
    input  logic        gmii_den,
    input  logic [7:0]  gmii_din,
    input  logic        phy_link_up,
    output logic        rx_vld,
    output logic [7:0]  rx_data,
    output logic        rx_sof,
    output logic        rx_eof,
    output logic        rx_bad,
    output logic [10:0] rx_len,
    output logic [15:0] cnt_good,
    output logic [15:0] cnt_runt,
    output logic [15:0] cnt_over,
    output logic [15:0] cnt_pre_err
);

    localparam logic [10:0] MIN_LEN_L = 11'(MIN_LEN);
    localparam logic [10:0] MAX_LEN_L = 11'(MAX_LEN);

    rx_state_t   state, state_nxt;
    logic [7:0]  hold_dat, hold_dat_nxt;
    logic        hold_full, hold_full_nxt;
    logic        hold_first, hold_first_nxt;
    logic [10:0] len, len_nxt;
    rx_beat_t    out_q, out_nxt;
    logic        inc_good, inc_runt, inc_over, inc_pre;

    always_comb begin
        state_nxt      = state;
        hold_dat_nxt   = hold_dat;
        hold_full_nxt  = hold_full;
        hold_first_nxt = hold_first;
        len_nxt        = len;
        out_nxt        = '0;
        inc_good       = 1'b0;
        inc_runt       = 1'b0;
        inc_over       = 1'b0;
        inc_pre        = 1'b0;

        if (!phy_link_up) begin
            // Link loss flushes whatever is held as a bad frame without touching statistics.
            state_nxt     = ST_IDLE;
            hold_full_nxt = 1'b0;
            len_nxt       = '0;
            if ((state == ST_DATA) && hold_full) begin
                out_nxt.vld = 1'b1;
                out_nxt.dat = hold_dat;
                out_nxt.sof = hold_first;
                out_nxt.eof = 1'b1;
                out_nxt.bad = 1'b1;
                out_nxt.len = len;
            end
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (gmii_den) begin
                        if (gmii_din == PREAMBLE_BYTE) begin
                            state_nxt = ST_PREAMBLE;
                        end else begin
                            state_nxt = ST_DROP;
                            inc_pre   = 1'b1;
                        end
                    end
                end
                ST_PREAMBLE: begin
                    if (!gmii_den) begin
                        state_nxt = ST_IDLE;
                        inc_pre   = 1'b1;
                    end else if (gmii_din == SFD_BYTE) begin
                        state_nxt     = ST_DATA;
                        hold_full_nxt = 1'b0;
                        len_nxt       = '0;
                    end else if (gmii_din != PREAMBLE_BYTE) begin
                        state_nxt = ST_DROP;
                        inc_pre   = 1'b1;
                    end
                end
                ST_DATA: begin
                    if (gmii_den) begin
                        if (len == MAX_LEN_L) begin
                            // Byte MAX_LEN+1 arrived: close the frame on the held byte and discard the rest.
                            out_nxt.vld   = 1'b1;
                            out_nxt.dat   = hold_dat;
                            out_nxt.sof   = hold_first;
                            out_nxt.eof   = 1'b1;
                            out_nxt.bad   = 1'b1;
                            out_nxt.len   = len;
                            inc_over      = 1'b1;
                            state_nxt     = ST_DROP;
                            hold_full_nxt = 1'b0;
                            len_nxt       = '0;
                        end else begin
                            if (hold_full) begin
                                out_nxt.vld = 1'b1;
                                out_nxt.dat = hold_dat;
                                out_nxt.sof = hold_first;
                            end
                            hold_dat_nxt   = gmii_din;
                            hold_full_nxt  = 1'b1;
                            hold_first_nxt = !hold_full;
                            len_nxt        = len + 11'd1;
                        end
                    end else begin
                        if (hold_full) begin
                            out_nxt.vld = 1'b1;
                            out_nxt.dat = hold_dat;
                            out_nxt.sof = hold_first;
                            out_nxt.eof = 1'b1;
                            out_nxt.bad = (len < MIN_LEN_L);
                            out_nxt.len = len;
                            inc_good    = (len >= MIN_LEN_L);
                            inc_runt    = (len < MIN_LEN_L);
                        end else begin
                            inc_runt = 1'b1;
                        end
                        state_nxt     = ST_IDLE;
                        hold_full_nxt = 1'b0;
                        len_nxt       = '0;
                    end
                end
                ST_DROP: begin
                    if (!gmii_den) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge gmii_clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            hold_dat   <= '0;
            hold_full  <= 1'b0;
            hold_first <= 1'b0;
            len        <= '0;
            out_q      <= '0;
        end else begin
            state      <= state_nxt;
            hold_dat   <= hold_dat_nxt;
            hold_full  <= hold_full_nxt;
            hold_first <= hold_first_nxt;
            len        <= len_nxt;
            out_q      <= out_nxt;
        end
    end

    assign rx_vld  = out_q.vld;
    assign rx_data = out_q.dat;
    assign rx_sof  = out_q.sof;
    assign rx_eof  = out_q.eof;
    assign rx_bad  = out_q.bad;
    assign rx_len  = out_q.len;

    sat_cnt16 u_cnt_good (
        .gmii_clk (gmii_clk),
        .rst      (rst),
        .inc      (inc_good),
        .cnt      (cnt_good)
    );

    sat_cnt16 u_cnt_runt (
        .gmii_clk (gmii_clk),
        .rst      (rst),
        .inc      (inc_runt),
        .cnt      (cnt_runt)
    );

    sat_cnt16 u_cnt_over (
        .gmii_clk (gmii_clk),
        .rst      (rst),
        .inc      (inc_over),
        .cnt      (cnt_over)
    );

    sat_cnt16 u_cnt_pre_err (
        .gmii_clk (gmii_clk),
        .rst      (rst),
        .inc      (inc_pre),
        .cnt      (cnt_pre_err)
    );

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Directed bench for gmii_rx_framer: expected beats queued as bytes are driven, popped as rx_vld appears.
module tb_gmii_rx_framer;
    import eth_rx_pkg::*;

    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;

    logic        gmii_clk = 1'b0;
    logic        rst;
    logic        gmii_den;
    logic [7:0]  gmii_din;
    logic        phy_link_up;
    logic        rx_vld;
    logic [7:0]  rx_data;
    logic        rx_sof;
    logic        rx_eof;
    logic        rx_bad;
    logic [10:0] rx_len;
    logic [15:0] cnt_good;
    logic [15:0] cnt_runt;
    logic [15:0] cnt_over;
    logic [15:0] cnt_pre_err;

    gmii_rx_framer #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
        .gmii_clk    (gmii_clk),
        .rst         (rst),
        .gmii_den    (gmii_den),
        .gmii_din    (gmii_din),
        .phy_link_up (phy_link_up),
        .rx_vld      (rx_vld),
        .rx_data     (rx_data),
        .rx_sof      (rx_sof),
        .rx_eof      (rx_eof),
        .rx_bad      (rx_bad),
        .rx_len      (rx_len),
        .cnt_good    (cnt_good),
        .cnt_runt    (cnt_runt),
        .cnt_over    (cnt_over),
        .cnt_pre_err (cnt_pre_err)
    );

    always #4 gmii_clk = ~gmii_clk;

    rx_beat_t sb[$];
    int total = 0;
    int bad = 0;
    int cyc_cnt = 0;
    int sof_cyc = -1;
    int first_dat_cyc = -1;
    logic [15:0] exp_good, exp_runt, exp_over, exp_pre;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        rx_beat_t obs;
        rx_beat_t exp;
        obs = {rx_vld, rx_data, rx_sof, rx_eof, rx_bad, rx_len};
        if (rx_vld) begin
            if (rx_sof) sof_cyc = cyc_cnt;
            if (sb.size() == 0) begin
                check("unexpected_beat", 32'(obs), 32'd0);
            end else begin
                exp = sb.pop_front();
                check("beat", 32'(obs), 32'(exp));
            end
        end else begin
            check("idle_fields_zero", 32'({rx_sof, rx_eof, rx_bad, rx_len}), 32'd0);
        end
    endtask

    // Drive one GMII cycle, then sample outputs 1ns after the edge that consumed it.
    task automatic cyc(input logic den, input logic [7:0] din);
        gmii_den = den;
        gmii_din = din;
        @(posedge gmii_clk);
        #1;
        cyc_cnt++;
        monitor();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00);
    endtask

    task automatic check_cnts(input string tag);
        check({tag, "_good"}, 32'(cnt_good), 32'(exp_good));
        check({tag, "_runt"}, 32'(cnt_runt), 32'(exp_runt));
        check({tag, "_over"}, 32'(cnt_over), 32'(exp_over));
        check({tag, "_pre"},  32'(cnt_pre_err), 32'(exp_pre));
        check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    // Preamble, SFD, n payload bytes base+i, then one cycle of gmii_den=0.
    task automatic send_frame(input int npre, input int n, input logic [7:0] base);
        rx_beat_t b;
        int last;
        for (int i = 0; i < npre; i++) cyc(1'b1, PREAMBLE_BYTE);
        cyc(1'b1, SFD_BYTE);
        last = (n > MAX_LEN) ? MAX_LEN : n;
        for (int i = 0; i < n; i++) begin
            if (i < last) begin
                b     = '0;
                b.vld = 1'b1;
                b.dat = base + 8'(i);
                b.sof = (i == 0);
                if (i == last - 1) begin
                    b.eof = 1'b1;
                    b.bad = (n > MAX_LEN) || (n < MIN_LEN);
                    b.len = 11'(last);
                end
                sb.push_back(b);
            end
            if (i == 0) first_dat_cyc = cyc_cnt;
            cyc(1'b1, base + 8'(i));
        end
        cyc(1'b0, 8'h00);
        if (n > MAX_LEN)      exp_over = sat_inc(exp_over);
        else if (n < MIN_LEN) exp_runt = sat_inc(exp_runt);
        else                  exp_good = sat_inc(exp_good);
    endtask

    // Preamble, SFD and 29 payload bytes; the 30th byte slot is left to the caller.
    task automatic frame_to_byte30(input logic [7:0] base, input logic push_last);
        rx_beat_t b;
        for (int i = 0; i < 7; i++) cyc(1'b1, PREAMBLE_BYTE);
        cyc(1'b1, SFD_BYTE);
        for (int i = 0; i < 29; i++) begin
            b     = '0;
            b.vld = 1'b1;
            b.dat = base + 8'(i);
            b.sof = (i == 0);
            if (i == 28) begin
                b.eof = 1'b1;
                b.bad = 1'b1;
                b.len = 11'd29;
            end
            if (i < 28 || push_last) sb.push_back(b);
            cyc(1'b1, base + 8'(i));
        end
    endtask

    initial begin
        exp_good = '0;
        exp_runt = '0;
        exp_over = '0;
        exp_pre  = '0;
        rst         = 1'b1;
        gmii_den    = 1'b0;
        gmii_din    = 8'h00;
        phy_link_up = 1'b1;
        cyc(1'b0, 8'h00);
        cyc(1'b0, 8'h00);
        check("reset_outputs", 32'({rx_vld, rx_data, rx_sof, rx_eof, rx_bad, rx_len}), 32'd0);
        check_cnts("reset");
        rst = 1'b0;
        idle(2);

        // Nominal 64-byte frame with a 7-byte preamble.
        send_frame(7, 64, 8'h00);
        check("first_byte_latency", 32'(sof_cyc - first_dat_cyc), 32'd2);
        idle(3);
        check_cnts("good64");

        send_frame(7, 10, 8'h40);
        idle(3);
        check_cnts("runt10");

        send_frame(7, 1600, 8'h00);
        idle(3);
        check_cnts("over1600");

        // Broken preamble, then two valid frames with minimum gap.
        cyc(1'b1, 8'h55);
        cyc(1'b1, 8'h55);
        cyc(1'b1, 8'hAA);
        cyc(1'b1, 8'h01);
        cyc(1'b1, 8'h02);
        cyc(1'b0, 8'h00);
        exp_pre = sat_inc(exp_pre);
        send_frame(7, 64, 8'h80);
        send_frame(3, 65, 8'hC0);
        idle(3);
        check_cnts("pre_err_b2b");

        // gmii_den drops during preamble.
        cyc(1'b1, 8'h55);
        cyc(1'b0, 8'h00);
        exp_pre = sat_inc(exp_pre);
        idle(2);
        check_cnts("pre_den_drop");

        // Length boundaries: 1, 0, MIN_LEN-1, MAX_LEN bytes.
        send_frame(7, 1, 8'h11);
        send_frame(7, 0, 8'h00);
        send_frame(7, MIN_LEN - 1, 8'h22);
        send_frame(1, MAX_LEN, 8'h20);
        idle(3);
        check_cnts("boundaries");

        // Link loss at byte 30: held byte 29 closes the frame as bad, counters untouched.
        frame_to_byte30(8'h60, 1'b1);
        phy_link_up = 1'b0;
        cyc(1'b1, 8'h60 + 8'd29);
        cyc(1'b1, 8'h60 + 8'd30);
        cyc(1'b0, 8'h00);
        phy_link_up = 1'b1;
        idle(3);
        check_cnts("link_drop");

        // Reset at byte 30: frame vanishes, counters clear.
        frame_to_byte30(8'h90, 1'b0);
        rst = 1'b1;
        cyc(1'b1, 8'h90 + 8'd29);
        cyc(1'b0, 8'h00);
        rst = 1'b0;
        exp_good = '0;
        exp_runt = '0;
        exp_over = '0;
        exp_pre  = '0;
        idle(3);
        check_cnts("rst_mid_frame");

        // Saturation of the runt counter.
        force dut.u_cnt_runt.cnt = 16'hFFFF;
        cyc(1'b0, 8'h00);
        release dut.u_cnt_runt.cnt;
        exp_runt = 16'hFFFF;
        cyc(1'b0, 8'h00);
        check("runt_preload", 32'(cnt_runt), 32'h0000FFFF);
        send_frame(7, 10, 8'h33);
        idle(3);
        check_cnts("runt_saturate");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gmii_rx_framer.md
GMII_RX_FRAMER -- requirements
Module: gmii_rx_framer

Interface
REQ-001 Parameter MIN_LEN, default 64, minimum legal frame length in bytes (DA through FCS).
REQ-002 Parameter MAX_LEN, default 1518, maximum legal frame length in bytes; SHALL be 1..2047.
REQ-003 gmii_clk  in  1  single clock, the 125 MHz receive clock driving gmii_den/gmii_din.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 gmii_den  in  1  receive data valid from the RGMII-to-GMII converter.
REQ-006 gmii_din  in  8  receive byte.
REQ-007 phy_link_up  in  1  PHY link status; low aborts reception.
REQ-008 rx_vld  out  1  rx_data carries a frame byte.
REQ-009 rx_data  out  8  frame byte, preamble/SFD stripped.
REQ-010 rx_sof  out  1  first byte of frame; qualified by rx_vld.
REQ-011 rx_eof  out  1  last byte of frame; qualified by rx_vld.
REQ-012 rx_bad  out  1  frame in error; valid with rx_eof.
REQ-013 rx_len  out  11  frame byte count; valid with rx_eof.
REQ-014 cnt_good, cnt_runt, cnt_over, cnt_pre_err  out  16 each  saturating event counters.

Function
REQ-015 FSM states: IDLE, PREAMBLE, DATA, DROP.
REQ-016 IDLE: gmii_den=1 and gmii_din=0x55 -> PREAMBLE; gmii_den=1 with any other byte -> DROP, cnt_pre_err+1.
REQ-017 PREAMBLE: 0x55 -> stay, any number of repeats; 0xD5 -> DATA; other byte -> DROP, cnt_pre_err+1; gmii_den=0 -> IDLE, cnt_pre_err+1.
REQ-018 DATA: each gmii_den=1 cycle accepts one byte into a one-byte hold register and increments an 11-bit length counter.
REQ-019 When a byte is accepted and the hold register is full, the held byte SHALL be emitted with rx_vld=1, rx_eof=0, and rx_sof=1 only for the frame's first byte.
REQ-020 gmii_den=0 in DATA: emit the held byte with rx_eof=1, rx_len=count, then go to IDLE.
REQ-021 All outputs are registered; a byte on gmii_din at cycle N appears on rx_data at cycle N+2, and rx_eof appears on the cycle after the last byte's output slot would otherwise be filled.
REQ-022 A one-byte frame SHALL assert rx_sof and rx_eof together.
REQ-023 Zero bytes after SFD (gmii_den falls right after 0xD5): no rx_vld is produced; cnt_runt+1.
REQ-024 At eof, rx_len<MIN_LEN -> rx_bad=1, cnt_runt+1; otherwise rx_bad=0, cnt_good+1.
REQ-025 Accepting byte MAX_LEN+1: emit the held byte (byte MAX_LEN) with rx_eof=1, rx_bad=1, rx_len=MAX_LEN; cnt_over+1; -> DROP.
REQ-026 DROP: discard input; gmii_den=0 -> IDLE.
REQ-027 phy_link_up=0 in any state -> IDLE next cycle; if in DATA with a held byte, emit it with rx_eof=1, rx_bad=1, no counter increment.
REQ-028 A new preamble may start on the cycle immediately after gmii_den falls; no minimum IFG is enforced.
REQ-029 Counters saturate at 0xFFFF and never wrap.
REQ-030 rx_sof, rx_eof, rx_bad, rx_len SHALL be 0 whenever rx_vld=0.

Reset
REQ-031 rst=1 -> FSM IDLE, hold register empty, length 0, all outputs 0, all counters 0, on the next gmii_clk edge.
REQ-032 rst mid-frame SHALL discard the frame silently: no rx_eof and no counter update.

Structure
REQ-033 FSM state encoding, preamble byte 0x55 and SFD byte 0xD5 constants SHALL reside in the shared eth_rx_pkg package.
REQ-034 Single sub-module sat_cnt16 (16-bit saturating incrementer with sync reset), instantiated four times; the rest is flat.

Verification
REQ-035 Seven bytes of 0x55, then 0xD5, then 64 bytes 0x00..0x3F, then gmii_den=0 -> 64 rx_vld; sof on 0x00; eof on 0x3F, rx_len=64, rx_bad=0, cnt_good=1, first byte at N+2.
REQ-036 Preamble, SFD, then 10 bytes -> eof with rx_len=10, rx_bad=1, cnt_runt=1.
REQ-037 Preamble, SFD, then 1600 bytes -> eof on byte 1518, rx_len=1518, rx_bad=1, cnt_over=1; no rx_vld for bytes 1519..1600.
REQ-038 Frame starting 0x55 0x55 0xAA -> no rx_vld, cnt_pre_err=1; a back-to-back valid frame with 0 IFG is received intact.
REQ-039 phy_link_up dropped at byte 30 -> eof+bad on byte 29 or 30 per REQ-027, no counter change; rst at byte 30 -> no eof, counters 0.
REQ-040 Force cnt_runt to 0xFFFF, send one more runt -> cnt_runt remains 0xFFFF.
